vec_exec_ctrl: RTL and testbench
================================

# vec_exec_ctrl

Sequencing stage that sits directly upstream of the 512-bit lane arithmetic unit (16 × 32-bit lanes, op 000 = add, 001 = multiply, 64-bit per-lane result split into low/high 512-bit halves). It owns a small vector register file and accepts one command at a time over a valid/ready handshake. For arithmetic commands it registers operands onto the arithmetic unit inputs, captures its low/high outputs and writes them back. Load/store commands move whole vectors between the host port and the register file.

## Interface
Parameters:
- NUM_REGS, 4: vector registers; power of two, index width RW = log2(NUM_REGS).
- VW, 512: vector width in bits; fixed to 16 lanes × 32.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  000 ADD, 001 MUL, 010 LOAD, 011 STORE, others illegal.
- cmd_rs1, cmd_rs2  in  RW  source registers (ADD/MUL).
- cmd_rd  in  RW  destination (ADD/MUL/LOAD) or source (STORE).
- cmd_data  in  VW  LOAD payload, sampled at acceptance.
- alu_a, alu_b  out  VW  registered operands to the arithmetic unit.
- alu_op  out  3  registered op to the arithmetic unit.
- alu_low, alu_high  in  VW  arithmetic unit results (combinational from alu_a/b/op).
- st_data  out  VW  STORE result, held until the next STORE or reset.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done for an illegal op.

## Operation
- States: IDLE, READ, EXEC, WB.
- cmd_ready = 1 only in IDLE and not in reset. Acceptance = cmd_valid & cmd_ready at an edge (E0). All cmd_* fields are latched at E0; later changes are ignored.
- E0: latch command, go to READ.
- READ (edge E1):
  - ADD/MUL: alu_a ← reg[rs1], alu_b ← reg[rs2], alu_op ← op; go to EXEC.
  - LOAD: reg[rd] ← latched cmd_data; done = 1; go to IDLE.
  - STORE: st_data ← reg[rd]; done = 1; go to IDLE.
  - Illegal: no register write; done = 1, err = 1; go to IDLE.
- EXEC (edge E2): res_lo ← alu_low, res_hi ← alu_high; go to WB.
- WB (edge E3): reg[rd] ← res_lo, reg[(rd+1) mod NUM_REGS] ← res_hi; done = 1; go to IDLE.
- Per-lane result width rules:
  - ADD: high lane = carry-out, 0 or 1.
  - MUL: high lane = upper 32 bits of the unsigned 32×32 product.
- rd+1 wraps: rd = NUM_REGS-1 writes its high half to reg 0.
- Source equal to a destination: operands are read at E1, before the write at E3, so the old value is used.
- alu_a, alu_b and alu_op hold their last values outside EXEC. The arithmetic unit output is only sampled in EXEC.

## Timing
- Reset: state IDLE; all registers, alu_a, alu_b, alu_op, st_data, done and err = 0. cmd_ready = 0 in the reset cycle and 1 in the first cycle after reset is released.
- Latency from acceptance edge E0:
  - ADD/MUL: done registered at E3 (3 cycles).
  - LOAD/STORE/illegal: done registered at E1 (1 cycle).
- Throughput:
  - Next command accepted no earlier than E4 (ADD/MUL) or E2 (others).
  - cmd_ready is low from E0 until done is asserted; it goes high in the same cycle done is high.
- done and err are high for exactly one cycle.
- rst asserted in any state: the in-flight command is abandoned, no write-back, no done, and all state is cleared at that edge.
- cmd_valid while cmd_ready = 0: ignored, not queued.

## Test plan
- Reset, then LOAD r0 = all lanes 0x0000_0005 and LOAD r1 = all lanes 0x0000_0003; ADD rd = 2 → done 3 cycles after acceptance; r2 lanes = 0x8, r3 lanes = 0x0; STORE r2 → st_data lanes 0x0000_0008.
- LOAD r0 and r1 = all lanes 0xFFFF_FFFF; ADD rd = 3 → r3 lanes 0xFFFF_FFFE; r0 (wrap) lanes 0x0000_0001.
- Same operands, MUL rd = 0 → r0 lanes 0x0000_0001, r1 lanes 0xFFFF_FFFE. Also checks rs = rd: operands are read before the write.
- Lane independence: lane i of r0 = i, lane i of r1 = 0x1000_0000·(i+1), MUL rd = 2 → each lane's r2/r3 equals the 64-bit product split.
- cmd_op = 110 → done and err high together 1 cycle after acceptance; every register unchanged (verified by STORE). cmd_valid held high during a busy period → exactly one acceptance per ready window.
- Accept MUL, assert rst at E2 → no done pulse, all registers and st_data = 0, cmd_ready returns to 1 the cycle after rst drops.

Source files
------------

// File: rtl/vec_exec_ctrl_if.sv
// Host command channel, arithmetic-unit operand/result bus and completion
// signals for the vector execution controller.
interface vec_exec_ctrl_if #(
    parameter int NUM_REGS = 4,
    parameter int VW       = 512
);
    localparam int RW = $clog2(NUM_REGS);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [RW-1:0]   cmd_rs1;
    logic [RW-1:0]   cmd_rs2;
    logic [RW-1:0]   cmd_rd;
    logic [VW-1:0]   cmd_data;
    logic [VW-1:0]   alu_a;
    logic [VW-1:0]   alu_b;
    logic [2:0]      alu_op;
    logic [VW-1:0]   alu_low;
    logic [VW-1:0]   alu_high;
    logic [VW-1:0]   st_data;
    logic            done;
    logic            err;

    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_data,
        output alu_low, alu_high,
        input  cmd_ready, alu_a, alu_b, alu_op, st_data, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_data,
        input  alu_low, alu_high,
        output cmd_ready, alu_a, alu_b, alu_op, st_data, done, err
    );
endinterface

// File: rtl/vec_exec_ctrl.sv
// Sequencer in front of the 16-lane arithmetic unit: owns the vector register
// file, runs one command at a time and writes low/high results back to rd, rd+1.
module vec_exec_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int VW       = 512
) (
    input  logic              clk,
    input  logic              rst,
    vec_exec_ctrl_if.slave    bus
);
    localparam int RW = $clog2(NUM_REGS);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t          state_q;
    logic [VW-1:0]   regs_q [NUM_REGS];
    logic [2:0]      op_q;
    logic [RW-1:0]   rs1_q;
    logic [RW-1:0]   rs2_q;
    logic [RW-1:0]   rd_q;
    logic [VW-1:0]   data_q;
    logic [VW-1:0]   res_lo_q;
    logic [VW-1:0]   res_hi_q;
    logic [VW-1:0]   alu_a_q;
    logic [VW-1:0]   alu_b_q;
    logic [2:0]      alu_op_q;
    logic [VW-1:0]   st_data_q;
    logic            done_q;
    logic            err_q;
    logic [RW-1:0]   rd_hi_d;

    // High half goes to rd+1, wrapping naturally in RW bits.
    assign rd_hi_d = rd_q + RW'(1);

    assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.st_data   = st_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    // Command sequencer, register file and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            op_q      <= 3'd0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= 3'd0;
            st_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q    <= bus.cmd_op;
                        rs1_q   <= bus.cmd_rs1;
                        rs2_q   <= bus.cmd_rs2;
                        rd_q    <= bus.cmd_rd;
                        data_q  <= bus.cmd_data;
                        state_q <= ST_READ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    case (op_q)
                        OP_ADD, OP_MUL: begin
                            alu_a_q  <= regs_q[rs1_q];
                            alu_b_q  <= regs_q[rs2_q];
                            alu_op_q <= op_q;
                            state_q  <= ST_EXEC;
                        end
                        OP_LOAD: begin
                            regs_q[rd_q] <= data_q;
                            done_q       <= 1'b1;
                            state_q      <= ST_IDLE;
                        end
                        OP_STORE: begin
                            st_data_q <= regs_q[rd_q];
                            done_q    <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                        default: begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
                ST_EXEC: begin
                    res_lo_q <= bus.alu_low;
                    res_hi_q <= bus.alu_high;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    // Sources were captured at READ, so overwriting them here is safe.
                    regs_q[rd_q]    <= res_lo_q;
                    regs_q[rd_hi_d] <= res_hi_q;
                    done_q          <= 1'b1;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vec_exec_ctrl.sv
// Scoreboard bench for vec_exec_ctrl with a lane-level arithmetic unit model
// and a whole-vector reference model of the register file.
module tb_vec_exec_ctrl;
    localparam int NUM_REGS = 4;
    localparam int VW       = 512;
    localparam int LANES    = 16;

    typedef struct {
        int            done_cyc;
        bit            err;
        bit            is_store;
        logic [VW-1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t          exp_q[$];
    exp_t          m_e;
    logic [VW-1:0] ref_q [NUM_REGS];
    logic [VW-1:0] alu_lo_s;
    logic [VW-1:0] alu_hi_s;

    vec_exec_ctrl_if #(.NUM_REGS(NUM_REGS), .VW(VW)) bus ();

    vec_exec_ctrl #(.NUM_REGS(NUM_REGS), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-lane 32x32 add/multiply producing a 64-bit result split into halves.
    function automatic void lane_op(input logic [2:0] op, input logic [VW-1:0] a,
                                    input logic [VW-1:0] b,
                                    output logic [VW-1:0] lo, output logic [VW-1:0] hi);
        lo = '0;
        hi = '0;
        for (int i = 0; i < LANES; i++) begin
            longint unsigned x = 64'(a[i*32 +: 32]);
            longint unsigned y = 64'(b[i*32 +: 32]);
            longint unsigned r;
            if (op == 3'd0)      r = x + y;
            else if (op == 3'd1) r = x * y;
            else                 r = 64'd0;
            lo[i*32 +: 32] = r[31:0];
            hi[i*32 +: 32] = r[63:32];
        end
    endfunction

    // The arithmetic unit the controller drives.
    always_comb begin
        alu_lo_s = '0;
        alu_hi_s = '0;
        lane_op(bus.alu_op, bus.alu_a, bus.alu_b, alu_lo_s, alu_hi_s);
    end
    assign bus.alu_low  = alu_lo_s;
    assign bus.alu_high = alu_hi_s;

    function automatic logic [VW-1:0] splat(input logic [31:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Issue one command, update the reference model and queue the expected completion.
    task automatic issue(input logic [2:0] op, input int rs1, input int rs2, input int rd,
                         input logic [VW-1:0] data, input bit hold);
        int            w = 0;
        exp_t          e;
        logic [VW-1:0] lo;
        logic [VW-1:0] hi;
        @(negedge clk);
        while (!bus.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) begin
            chk("ready_timeout", bus.cmd_ready, 1);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rs1   = 2'(rs1);
        bus.cmd_rs2   = 2'(rs2);
        bus.cmd_rd    = 2'(rd);
        bus.cmd_data  = data;
        e.err      = (op > 3'd3);
        e.is_store = (op == 3'd3);
        e.st       = '0;
        e.done_cyc = cyc + ((op <= 3'd1) ? 4 : 2);
        if (op <= 3'd1) begin
            lane_op(op, ref_q[rs1], ref_q[rs2], lo, hi);
            ref_q[rd] = lo;
            ref_q[(rd + 1) % NUM_REGS] = hi;
        end else if (op == 3'd2) begin
            ref_q[rd] = data;
        end else if (op == 3'd3) begin
            e.st = ref_q[rd];
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            w = 0;
            // Keep valid asserted with changing fields while busy; none may be taken.
            while (!bus.cmd_ready && w < 10) begin
                bus.cmd_op   = 3'($urandom);
                bus.cmd_rd   = 2'($urandom);
                bus.cmd_data = rand_vec();
                @(negedge clk);
                w++;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic store_all();
        for (int r = 0; r < NUM_REGS; r++) issue(3'd3, 0, 0, r, '0, 1'b0);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 512'(exp_q.size()), 0);
    endtask

    // Monitor: every done pulse is matched against the oldest expected completion.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.err && !bus.done) chk("err_without_done", bus.done, 1);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", bus.done, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("done_cycle", 512'(cyc), 512'(m_e.done_cyc));
                    chk("err", bus.err, m_e.err);
                    chk("ready_with_done", bus.cmd_ready, 1);
                    if (m_e.is_store) chk("st_data", bus.st_data, m_e.st);
                end
            end
        end
    end

    initial begin
        logic [VW-1:0] v0;
        logic [VW-1:0] v1;
        logic [2:0]    op;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_rs1   = 2'd0;
        bus.cmd_rs2   = 2'd0;
        bus.cmd_rd    = 2'd0;
        bus.cmd_data  = '0;
        for (int r = 0; r < NUM_REGS; r++) ref_q[r] = '0;

        repeat (2) @(negedge clk);
        chk("ready_in_reset", bus.cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.cmd_ready, 1);
        chk("done_after_reset", bus.done, 0);
        chk("err_after_reset", bus.err, 0);
        chk("st_data_after_reset", bus.st_data, '0);
        chk("alu_a_after_reset", bus.alu_a, '0);
        chk("alu_b_after_reset", bus.alu_b, '0);
        chk("alu_op_after_reset", bus.alu_op, 0);

        // Basic add with zero carry into the high register.
        issue(3'd2, 0, 0, 0, splat(32'h0000_0005), 1'b0);
        issue(3'd2, 0, 0, 1, splat(32'h0000_0003), 1'b0);
        issue(3'd0, 0, 1, 2, '0, 1'b0);
        issue(3'd3, 0, 0, 2, '0, 1'b0);
        issue(3'd3, 0, 0, 3, '0, 1'b0);
        drain();
        chk("add_plan_r2", ref_q[2], splat(32'h0000_0008));

        // Carry out with rd = last register wrapping to r0.
        issue(3'd2, 0, 0, 0, splat(32'hFFFF_FFFF), 1'b0);
        issue(3'd2, 0, 0, 1, splat(32'hFFFF_FFFF), 1'b0);
        issue(3'd0, 0, 1, 3, '0, 1'b0);
        issue(3'd3, 0, 0, 3, '0, 1'b0);
        issue(3'd3, 0, 0, 0, '0, 1'b0);

        // Multiply overwriting its own sources.
        issue(3'd2, 0, 0, 0, splat(32'hFFFF_FFFF), 1'b0);
        issue(3'd2, 0, 0, 1, splat(32'hFFFF_FFFF), 1'b0);
        issue(3'd1, 0, 1, 0, '0, 1'b0);
        store_all();

        // Lane independence.
        for (int i = 0; i < LANES; i++) begin
            v0[i*32 +: 32] = 32'(i);
            v1[i*32 +: 32] = 32'(32'h1000_0000 * (i + 1));
        end
        issue(3'd2, 0, 0, 0, v0, 1'b0);
        issue(3'd2, 0, 0, 1, v1, 1'b1);
        issue(3'd1, 0, 1, 2, '0, 1'b1);
        store_all();

        // Illegal opcode with valid held high across the busy window.
        issue(3'd6, 1, 2, 3, rand_vec(), 1'b1);
        store_all();
        drain();

        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom_range(0, 9) > 7 ? 3 : $urandom_range(0, 7));
            issue(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  rand_vec(), 1'($urandom_range(0, 1)));
        end
        store_all();
        drain();

        // Reset landing on the EXEC edge of a multiply.
        issue(3'd1, 0, 1, 2, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        for (int r = 0; r < NUM_REGS; r++) ref_q[r] = '0;
        @(negedge clk);
        chk("ready_during_rst", bus.cmd_ready, 0);
        chk("st_data_at_rst", bus.st_data, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.cmd_ready, 1);
        chk("done_after_rst", bus.done, 0);
        chk("alu_a_after_rst", bus.alu_a, '0);
        chk("alu_op_after_rst", bus.alu_op, 0);
        repeat (3) @(negedge clk);
        store_all();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
